// File: rtl/vmul_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// vmul_pkg
// Shared types and helpers for the vector multiply sequencer.
//   sew_e     element width encoding seen by the multiplier array
//   state_e   sequencer FSM states
//   NUM_LANES number of 8x8 lanes in the shared array
//   PP_W      width of one lane product
//   pp_shift  byte offset of lane k's product inside the 64-bit result
// -----------------------------------------------------------------------------
package vmul_pkg;

    typedef enum logic [1:0] {
        SEW8  = 2'b00,
        SEW16 = 2'b01,
        SEW32 = 2'b10
    } sew_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_e;

    localparam int NUM_LANES = 8;
    localparam int PP_W      = 16;
    localparam int ACC_W     = 64;

    // The one sew encoding the array cannot execute.
    localparam logic [1:0] SEW_BAD = 2'b11;

    // Byte position (i+j, plus the element base for SEW8/SEW16) at which lane
    // k's product lands in the result. For SEW8 only lanes 0..3 carry data and
    // the caller masks the rest, so the wrapped value for k>=4 is never used.
    function automatic logic [2:0] pp_shift(logic [1:0] sew, logic pass, int k);
        int byteIdx;
        byteIdx = 0;
        case (sew)
            SEW8:    byteIdx = 2 * k;
            SEW16:   byteIdx = 4 * (k / 4) + ((k / 2) % 2) + (k % 2);
            SEW32:   byteIdx = 2 * int'(pass) + (k / 4) + (k % 4);
            default: byteIdx = 0;
        endcase
        return byteIdx[2:0];
    endfunction

endpackage

// File: rtl/vmul_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// vmul_seq_ctrl_if
// Bundles the request, array and result signals of the vector multiply
// sequencer.
//   slave  : the sequencer side (consumes requests and products, produces
//            array operands and results)
//   master : the requester / array side
// Signals:
//   req_valid/req_ready/req_sew/req_a/req_b  request handshake and operands
//   mul_a/mul_b/mul_sew/mul_count_0          operands and pass select to array
//   pp_in                                    8 x 16-bit lane products
//   res_valid/res_ready/res_data/res_err     result handshake
//   busy                                     sequencer not idle
// -----------------------------------------------------------------------------
interface vmul_seq_ctrl_if
    import vmul_pkg::*;
;
    logic                        req_valid;
    logic                        req_ready;
    logic [1:0]                  req_sew;
    logic [31:0]                 req_a;
    logic [31:0]                 req_b;
    logic [31:0]                 mul_a;
    logic [31:0]                 mul_b;
    logic [1:0]                  mul_sew;
    logic                        mul_count_0;
    logic [NUM_LANES*PP_W-1:0]   pp_in;
    logic                        res_valid;
    logic                        res_ready;
    logic [ACC_W-1:0]            res_data;
    logic                        res_err;
    logic                        busy;

    modport slave (
        input  req_valid, req_sew, req_a, req_b, pp_in, res_ready,
        output req_ready, mul_a, mul_b, mul_sew, mul_count_0,
               res_valid, res_data, res_err, busy
    );

    modport master (
        output req_valid, req_sew, req_a, req_b, pp_in, res_ready,
        input  req_ready, mul_a, mul_b, mul_sew, mul_count_0,
               res_valid, res_data, res_err, busy
    );

endinterface

// File: rtl/vmul_seq_ctrl_pp_accum.sv
// -----------------------------------------------------------------------------
// vmul_pp_accum
// Places the eight lane products of one array pass at their byte offsets,
// sums them at full 64-bit width and accumulates across passes.
//   clk, reset : clock and synchronous active-high reset
//   clear_i    : zero the accumulator (new request accepted)
//   add_i      : add this pass's shifted products (sample cycle)
//   sew_i      : element width of the active request
//   pass_i     : active pass (only meaningful for SEW32)
//   pp_i       : lane products, lane k at pp_i[16k +: 16]
//   acc_o      : accumulated 64-bit result
// -----------------------------------------------------------------------------
module vmul_pp_accum
    import vmul_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear_i,
    input  logic                      add_i,
    input  logic [1:0]                sew_i,
    input  logic                      pass_i,
    input  logic [NUM_LANES*PP_W-1:0] pp_i,
    output logic [ACC_W-1:0]          acc_o
);

    logic [ACC_W-1:0] passSum;
    logic [ACC_W-1:0] acc_q;

    // Shift-add of one pass. Every element's partial products sum to exactly
    // its element-width product, so no carry can leak into the neighbouring
    // element and the plain 64-bit add is exact. SEW8 only uses lanes 0..3.
    always_comb begin
        passSum = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (!(sew_i == SEW8 && k >= 4)) begin
                passSum = passSum +
                    (ACC_W'(pp_i[PP_W*k +: PP_W]) << {pp_shift(sew_i, pass_i, k), 3'b000});
            end
        end
    end

    // Accumulator: cleared when a request is accepted, bumped on each sample.
    // Clear and add never coincide because the sequencer only samples after
    // it has left IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else if (clear_i) begin
            acc_q <= '0;
        end else if (add_i) begin
            acc_q <= acc_q + passSum;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/vmul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// vmul_seq_ctrl
// Sequencer for the shared 8-lane 8x8 multiplier array. Takes one unsigned
// element-wise multiply request, holds the array operands, runs one pass
// (SEW8/SEW16) or two passes (SEW32), and returns the 64-bit result over a
// valid/ready handshake. Illegal sew returns res_err with zero data and no
// array pass.
//   MUL_LAT : cycles from mul_* driven to matching pp_in (0..7, 0 = comb array)
//   clk     : clock
//   reset   : synchronous active-high reset, aborts any request in flight
//   bus     : request, array and result signals (slave modport)
// -----------------------------------------------------------------------------
module vmul_seq_ctrl
    import vmul_pkg::*;
#(
    parameter int MUL_LAT = 1
) (
    input  logic           clk,
    input  logic           reset,
    vmul_seq_ctrl_if.slave bus
);

    localparam logic [2:0] LAT = 3'(MUL_LAT);

    state_e           state_q, state_d;
    logic             pass_q, pass_d;
    logic [2:0]       wait_q, wait_d;
    logic [31:0]      mulA_q, mulB_q;
    logic [1:0]       mulSew_q;
    logic             reqErr_q;
    logic             accept;
    logic             sample;
    logic [ACC_W-1:0] acc;

    // Next-state logic. A pass is issued in ISSUE and its products are
    // sampled MUL_LAT cycles later (in ISSUE itself when the array is
    // combinational). WAIT counts 1..MUL_LAT so the sample lands on its last
    // cycle. An illegal request skips the array and goes straight to DONE.
    // The pass counter is cleared on the result handshake so mul_count_0
    // rests at 0 between requests.
    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        wait_d  = wait_q;
        accept  = 1'b0;
        sample  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    pass_d  = 1'b0;
                    wait_d  = 3'd0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (reqErr_q) begin
                    state_d = DONE;
                end else if (LAT == 3'd0) begin
                    sample = 1'b1;
                end else begin
                    wait_d  = 3'd1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (wait_q == LAT) begin
                    sample = 1'b1;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    pass_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (sample) begin
            wait_d = 3'd0;
            if (mulSew_q == SEW32 && !pass_q) begin
                pass_d  = 1'b1;
                state_d = ISSUE;
            end else begin
                state_d = DONE;
            end
        end
    end

    // FSM, pass counter and latency counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pass_q  <= 1'b0;
            wait_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            wait_q  <= wait_d;
        end
    end

    // Operand capture. The array operands only move on a legal accept, so an
    // illegal request leaves the array inputs untouched; its error flag is
    // kept separately to steer ISSUE and qualify the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            mulA_q   <= '0;
            mulB_q   <= '0;
            mulSew_q <= '0;
            reqErr_q <= 1'b0;
        end else if (accept) begin
            reqErr_q <= (bus.req_sew == SEW_BAD);
            if (bus.req_sew != SEW_BAD) begin
                mulA_q   <= bus.req_a;
                mulB_q   <= bus.req_b;
                mulSew_q <= bus.req_sew;
            end
        end
    end

    vmul_pp_accum u_accum (
        .clk     (clk),
        .reset   (reset),
        .clear_i (accept),
        .add_i   (sample),
        .sew_i   (mulSew_q),
        .pass_i  (pass_q),
        .pp_i    (bus.pp_in),
        .acc_o   (acc)
    );

    // Outputs are straight decodes of registered state, so the result and
    // array operands stay stable while the FSM sits in a state.
    assign bus.req_ready   = (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.res_valid   = (state_q == DONE);
    assign bus.res_err     = (state_q == DONE) && reqErr_q;
    assign bus.res_data    = acc;
    assign bus.mul_a       = mulA_q;
    assign bus.mul_b       = mulB_q;
    assign bus.mul_sew     = mulSew_q;
    assign bus.mul_count_0 = pass_q;

endmodule
